// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: depth helpers and Gray/binary
// conversion functions usable at any pointer width up to 32 bits.
package fifo_pkg;

  localparam int PTR_SZ_DEFAULT = 2;
  localparam int DEPTH = 1 << PTR_SZ_DEFAULT;

  function automatic int depth_of(input int ptr_sz);
    return 1 << ptr_sz;
  endfunction

  // Callers zero-extend narrower pointers and truncate the result back.
  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(input logic [31:0] g, input int w);
    logic [31:0] b;
    b = '0;
    for (int i = 31; i >= 0; i--) begin
      if (i == w - 1) b[i] = g[i];
      else if (i < w - 1) b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_full_gray2bin.sv
// Gray-to-binary converter: each binary bit is the XOR of all Gray bits at or
// above it, written as independent reductions so there is no feedback net.
module gray2bin #(
  parameter int W = 3
) (
  input  logic [W-1:0] gray_i,
  output logic [W-1:0] bin_o
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin_o[i] = ^(gray_i >> i);
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer and flag logic of the dual-clock FIFO. All flags are
// registered from the next write pointer so they reflect a write in the same edge.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int PTR_SZ    = PTR_SZ_DEFAULT,
  parameter int AFULL_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rq2_raddr,
  output logic              wen,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel,
  output logic              wovf
);

  localparam int PW = PTR_SZ + 1;

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wgray_q, wgray_d;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wfull_q, wfull_d;
  logic          wafull_q, wafull_d;
  logic          wovf_q, wovf_d;
  logic [PW-1:0] rbin;
  logic [PW-1:0] full_cmp;

  gray2bin #(.W(PW)) u_rq2_bin (
    .gray_i (rq2_raddr),
    .bin_o  (rbin)
  );

  always_comb begin
    wen      = winc & ~wfull_q;
    wbin_d   = wbin_q + PW'(wen);
    wgray_d  = PW'(bin2gray(32'(wbin_d)));
    // Full when the write pointer has lapped the read pointer exactly once.
    full_cmp = {~rq2_raddr[PTR_SZ:PTR_SZ-1], rq2_raddr[PTR_SZ-2:0]};
    wfull_d  = (wgray_d == full_cmp);
    wlevel_d = wbin_d - rbin;
    wafull_d = (32'(wlevel_d) >= 32'(AFULL_THR));
    wovf_d   = wovf_q | (winc & wfull_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wlevel_q <= '0;
      wfull_q  <= 1'b0;
      wafull_q <= 1'b0;
      wovf_q   <= 1'b0;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wlevel_q <= wlevel_d;
      wfull_q  <= wfull_d;
      wafull_q <= wafull_d;
      wovf_q   <= wovf_d;
    end
  end

  assign waddr        = wbin_q[PTR_SZ-1:0];
  assign waddr_gray   = wgray_q;
  assign wfull        = wfull_q;
  assign walmost_full = wafull_q;
  assign wlevel       = wlevel_q;
  assign wovf         = wovf_q;

endmodule
